// File: rtl/mc_scoreboard_if.sv
// rtl/mc_scoreboard_if.sv - ID/EXE hazard-query and completion signal bundle for mc_scoreboard
interface mc_scoreboard_if #(
    parameter int LAT_W = 6
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [4:0]       id_rs3;
    logic             id_rs1_fp;
    logic             id_rs2_fp;
    logic             id_rs3_fp;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic             id_rs3_used;
    logic [4:0]       id_rd;
    logic             id_rd_fp;
    logic             id_rd_we;
    logic             id_is_mc;
    logic             exe_mc_start;
    logic             exe_flush;
    logic [4:0]       exe_rd;
    logic             exe_rd_fp;
    logic             exe_rd_we;
    logic [LAT_W-1:0] exe_mc_lat;
    logic             stall_pipl;
    logic             rd_busy;
    logic             multicycle_hazard;
    logic             mc_busy;
    logic             mc_done;
    logic [4:0]       mc_rd;
    logic             mc_rd_fp;
    logic             mc_err;

    modport master (
        output id_rs1, id_rs2, id_rs3, id_rs1_fp, id_rs2_fp, id_rs3_fp,
               id_rs1_used, id_rs2_used, id_rs3_used, id_rd, id_rd_fp, id_rd_we, id_is_mc,
               exe_mc_start, exe_flush, exe_rd, exe_rd_fp, exe_rd_we, exe_mc_lat, stall_pipl,
        input  rd_busy, multicycle_hazard, mc_busy, mc_done, mc_rd, mc_rd_fp, mc_err
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs3, id_rs1_fp, id_rs2_fp, id_rs3_fp,
               id_rs1_used, id_rs2_used, id_rs3_used, id_rd, id_rd_fp, id_rd_we, id_is_mc,
               exe_mc_start, exe_flush, exe_rd, exe_rd_fp, exe_rd_we, exe_mc_lat, stall_pipl,
        output rd_busy, multicycle_hazard, mc_busy, mc_done, mc_rd, mc_rd_fp, mc_err
    );
endinterface

// File: rtl/mc_scoreboard.sv
// rtl/mc_scoreboard.sv - multicycle unit tracker and int/FP destination busy map
// Optional MC_EARLY_RELEASE_EN: drop RAW on a source retiring this cycle (writeback forward).
module mc_scoreboard #(
    parameter int LAT_W         = 6,
    parameter int NUM_ARCH_REGS = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    mc_scoreboard_if.slave    sb
);
    localparam int MAP_W = 2 * NUM_ARCH_REGS;
    localparam int IDX_W = $clog2(MAP_W);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [LAT_W-1:0] r_cnt, w_cnt_nxt;
    logic [MAP_W-1:0] r_busy, w_busy_nxt;
    logic [4:0]       r_rd;
    logic             r_rd_fp;
    logic             r_rd_we;
    logic             r_err;

    logic             w_start, w_release, w_accept, w_lat_le1, w_err_set;
    logic [2:0]       w_rs_raw, w_rs_fwd;

    function automatic logic [IDX_W-1:0] map_idx(input logic fp, input logic [4:0] r);
        return IDX_W'(r) + (fp ? IDX_W'(NUM_ARCH_REGS) : IDX_W'(0));
    endfunction

    // Int x0 is hardwired, so it can never be a hazard source or a busy destination.
    function automatic logic reg_busy(input logic [MAP_W-1:0] map, input logic fp,
                                      input logic [4:0] r);
        return map[map_idx(fp, r)] & (fp | (r != 5'd0));
    endfunction

    assign w_start   = sb.exe_mc_start & ~sb.exe_flush;
    assign w_release = (r_state == S_DONE) & ~sb.stall_pipl;
    assign w_accept  = w_start & ((r_state == S_IDLE) | w_release);
    assign w_lat_le1 = (sb.exe_mc_lat <= LAT_W'(1));
    assign w_err_set = (w_start & ~w_accept) | (w_accept & (sb.exe_mc_lat == '0));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: w_state_nxt = S_IDLE;
            S_RUN: begin
                w_cnt_nxt = r_cnt - LAT_W'(1);
                if (r_cnt <= LAT_W'(1)) w_state_nxt = S_DONE;
            end
            S_DONE: if (!sb.stall_pipl) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_accept) begin
            w_state_nxt = w_lat_le1 ? S_DONE : S_RUN;
            w_cnt_nxt   = w_lat_le1 ? '0 : sb.exe_mc_lat - LAT_W'(1);
        end
    end

    // Clear first, then set, so a retire and a new start on the same register leave it busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_release && r_rd_we)
            w_busy_nxt[map_idx(r_rd_fp, r_rd)] = 1'b0;
        if (w_accept && sb.exe_rd_we && (sb.exe_rd_fp || (sb.exe_rd != 5'd0)))
            w_busy_nxt[map_idx(sb.exe_rd_fp, sb.exe_rd)] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= '0;
            r_rd    <= '0;
            r_rd_fp <= 1'b0;
            r_rd_we <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
            if (w_err_set) r_err <= 1'b1;
            if (w_accept) begin
                r_rd    <= sb.exe_rd;
                r_rd_fp <= sb.exe_rd_fp;
                r_rd_we <= sb.exe_rd_we;
            end
        end
    end

`ifdef MC_EARLY_RELEASE_EN
    assign w_rs_fwd = {w_release & r_rd_we & (sb.id_rs3_fp == r_rd_fp) & (sb.id_rs3 == r_rd),
                       w_release & r_rd_we & (sb.id_rs2_fp == r_rd_fp) & (sb.id_rs2 == r_rd),
                       w_release & r_rd_we & (sb.id_rs1_fp == r_rd_fp) & (sb.id_rs1 == r_rd)};
`else
    assign w_rs_fwd = 3'b000;
`endif

    assign w_rs_raw[0] = sb.id_rs1_used & reg_busy(r_busy, sb.id_rs1_fp, sb.id_rs1) & ~w_rs_fwd[0];
    assign w_rs_raw[1] = sb.id_rs2_used & reg_busy(r_busy, sb.id_rs2_fp, sb.id_rs2) & ~w_rs_fwd[1];
    assign w_rs_raw[2] = sb.id_rs3_used & reg_busy(r_busy, sb.id_rs3_fp, sb.id_rs3) & ~w_rs_fwd[2];

    assign sb.mc_busy           = (r_state != S_IDLE);
    assign sb.mc_done           = (r_state == S_DONE);
    assign sb.mc_rd             = (r_state == S_DONE) ? r_rd : 5'd0;
    assign sb.mc_rd_fp          = (r_state == S_DONE) & r_rd_fp;
    assign sb.mc_err            = r_err;
    assign sb.rd_busy           = sb.id_rd_we & reg_busy(r_busy, sb.id_rd_fp, sb.id_rd);
    assign sb.multicycle_hazard = (sb.id_is_mc & (r_state != S_IDLE) & ~w_release) | (|w_rs_raw);
endmodule

// File: tb/tb_mc_scoreboard.sv
// tb/tb_mc_scoreboard.sv - directed self-checking bench for mc_scoreboard
module tb_mc_scoreboard;
    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_err;
    logic saw_done;

    mc_scoreboard_if #(.LAT_W(6)) sb ();

    mc_scoreboard #(.LAT_W(6), .NUM_ARCH_REGS(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sb      (sb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_in();
        sb.id_rs1 = '0; sb.id_rs2 = '0; sb.id_rs3 = '0;
        sb.id_rs1_fp = 0; sb.id_rs2_fp = 0; sb.id_rs3_fp = 0;
        sb.id_rs1_used = 0; sb.id_rs2_used = 0; sb.id_rs3_used = 0;
        sb.id_rd = '0; sb.id_rd_fp = 0; sb.id_rd_we = 0; sb.id_is_mc = 0;
        sb.exe_mc_start = 0; sb.exe_flush = 0; sb.exe_rd = '0; sb.exe_rd_fp = 0;
        sb.exe_rd_we = 0; sb.exe_mc_lat = '0; sb.stall_pipl = 0;
    endtask

    task automatic start_op(input logic [4:0] rd, input logic fp, input logic [5:0] lat);
        sb.exe_mc_start = 1; sb.exe_rd = rd; sb.exe_rd_fp = fp; sb.exe_rd_we = 1; sb.exe_mc_lat = lat;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        clr_in();
        reset_n = 0;
        tick(); tick();
        sb.id_rd = 5'd4; sb.id_rd_we = 1; sb.id_is_mc = 1; sb.id_rs1 = 5'd4; sb.id_rs1_used = 1;
        #1;
        chk("rst_busy", sb.mc_busy, 0);
        chk("rst_done", sb.mc_done, 0);
        chk("rst_err", sb.mc_err, 0);
        chk("rst_rd_busy", sb.rd_busy, 0);
        chk("rst_hazard", sb.multicycle_hazard, 0);
        chk("rst_mc_rd", sb.mc_rd, 0);
        clr_in();
        reset_n = 1;
        tick();

        // div x5 lat=4 with dependent add x6,x5,x1 in ID
        start_op(5'd5, 0, 6'd4);
        sb.id_rs1 = 5'd5; sb.id_rs1_used = 1; sb.id_rs2 = 5'd1; sb.id_rs2_used = 1;
        sb.id_rd = 5'd6; sb.id_rd_we = 1;
        #1;
        chk("a_c0_hazard", sb.multicycle_hazard, 0);
        tick();
        sb.exe_mc_start = 0;
        for (int i = 1; i <= 3; i++) begin
            #1;
            chk($sformatf("a_c%0d_hazard", i), sb.multicycle_hazard, 1);
            chk($sformatf("a_c%0d_done", i), sb.mc_done, 0);
            tick();
        end
        chk("a_c4_done", sb.mc_done, 1);
        chk("a_c4_rd", sb.mc_rd, 5);
        chk("a_c4_rd_fp", sb.mc_rd_fp, 0);
`ifdef MC_EARLY_RELEASE_EN
        chk("a_c4_hazard", sb.multicycle_hazard, 0);
`else
        chk("a_c4_hazard", sb.multicycle_hazard, 1);
`endif
        tick();
        chk("a_c5_hazard", sb.multicycle_hazard, 0);
        chk("a_c5_done", sb.mc_done, 0);
        chk("a_c5_busy", sb.mc_busy, 0);
        clr_in();

        // fdiv f3 lat=3, WAW on f3 only, stalled DONE, back-to-back issue in release cycle
        start_op(5'd3, 1, 6'd3);
        sb.id_rd = 5'd3; sb.id_rd_fp = 1; sb.id_rd_we = 1;
        #1;
        chk("b_c0_rd_busy", sb.rd_busy, 0);
        tick();
        sb.exe_mc_start = 0;
        #1;
        chk("b_c1_f3_busy", sb.rd_busy, 1);
        sb.id_rd_fp = 0;
        #1;
        chk("b_c1_x3_busy", sb.rd_busy, 0);
        sb.id_rd_fp = 1;
        tick();
        chk("b_c2_f3_busy", sb.rd_busy, 1);
        tick();
        sb.stall_pipl = 1; sb.id_is_mc = 1;
        #1;
        chk("b_c3_done", sb.mc_done, 1);
        chk("b_c3_rd", sb.mc_rd, 3);
        chk("b_c3_rd_fp", sb.mc_rd_fp, 1);
        chk("b_c3_f3_busy", sb.rd_busy, 1);
        chk("b_c3_struct", sb.multicycle_hazard, 1);
        tick();
        chk("b_c4_done", sb.mc_done, 1);
        chk("b_c4_f3_busy", sb.rd_busy, 1);
        tick();
        sb.stall_pipl = 0;
        start_op(5'd7, 0, 6'd2);
        #1;
        chk("b_c5_done", sb.mc_done, 1);
        chk("b_c5_f3_busy", sb.rd_busy, 1);
        chk("b_c5_struct", sb.multicycle_hazard, 0);
        tick();
        sb.exe_mc_start = 0; sb.id_is_mc = 0;
        #1;
        chk("b_c6_f3_busy", sb.rd_busy, 0);
        chk("b_c6_busy", sb.mc_busy, 1);
        chk("b_c6_done", sb.mc_done, 0);
        sb.id_rd = 5'd7; sb.id_rd_fp = 0;
        #1;
        chk("b_c6_x7_busy", sb.rd_busy, 1);
        tick();
        chk("b_c7_done", sb.mc_done, 1);
        chk("b_c7_rd", sb.mc_rd, 7);
        chk("b_c7_err", sb.mc_err, 0);
        tick();
        chk("b_c8_busy", sb.mc_busy, 0);
        clr_in();

        // x0 destination never busy; lat=1 on f0 (a normal register)
        start_op(5'd0, 0, 6'd2);
        tick();
        sb.exe_mc_start = 0;
        sb.id_rd = 5'd0; sb.id_rd_we = 1; sb.id_rs1 = 5'd0; sb.id_rs1_used = 1;
        #1;
        chk("c_busy", sb.mc_busy, 1);
        chk("c_x0_rd_busy", sb.rd_busy, 0);
        chk("c_x0_hazard", sb.multicycle_hazard, 0);
        tick();
        chk("c_done", sb.mc_done, 1);
        chk("c_rd", sb.mc_rd, 0);
        tick();
        clr_in();
        start_op(5'd0, 1, 6'd1);
        tick();
        sb.exe_mc_start = 0;
        sb.id_rd = 5'd0; sb.id_rd_fp = 1; sb.id_rd_we = 1;
        #1;
        chk("c_lat1_done", sb.mc_done, 1);
        chk("c_lat1_rd_fp", sb.mc_rd_fp, 1);
        chk("c_f0_busy", sb.rd_busy, 1);
        tick();
        chk("c_f0_free", sb.rd_busy, 0);
        chk("c_lat1_idle", sb.mc_busy, 0);
        clr_in();

        // start during RUN is ignored and flags error; flushed start in IDLE does nothing
        start_op(5'd9, 0, 6'd3);
        tick();
        start_op(5'd10, 0, 6'd1);
        #1;
        chk("d_err_pre", sb.mc_err, 0);
        tick();
        clr_in();
        sb.id_rd = 5'd10; sb.id_rd_we = 1;
        #1;
        chk("d_err_set", sb.mc_err, 1);
        chk("d_x10_busy", sb.rd_busy, 0);
        chk("d_c2_done", sb.mc_done, 0);
        tick();
        chk("d_c3_done", sb.mc_done, 1);
        chk("d_c3_rd", sb.mc_rd, 9);
        tick();
        chk("d_idle", sb.mc_busy, 0);
        chk("d_err_sticky", sb.mc_err, 1);
        start_op(5'd11, 0, 6'd2);
        sb.exe_flush = 1;
        tick();
        clr_in();
        sb.id_rd = 5'd11; sb.id_rd_we = 1;
        #1;
        chk("d_flush_busy", sb.mc_busy, 0);
        chk("d_flush_rd_busy", sb.rd_busy, 0);
        clr_in();

        // reset mid-RUN: everything clears at once and the lost op never completes
        start_op(5'd12, 0, 6'd20);
        tick();
        sb.exe_mc_start = 0;
        for (int i = 0; i < 4; i++) tick();
        sb.id_rd = 5'd12; sb.id_rd_we = 1;
        #1;
        chk("e_pre_x12_busy", sb.rd_busy, 1);
        reset_n = 0;
        #1;
        chk("e_rst_busy", sb.mc_busy, 0);
        chk("e_rst_x12_busy", sb.rd_busy, 0);
        chk("e_rst_done", sb.mc_done, 0);
        chk("e_rst_err", sb.mc_err, 0);
        tick();
        reset_n = 1;
        saw_done = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            saw_done = saw_done | sb.mc_done;
        end
        chk("e_no_late_done", saw_done, 0);
        clr_in();

        // lat=0 is treated as 1 and raises the error flag
        start_op(5'd13, 0, 6'd0);
        tick();
        sb.exe_mc_start = 0;
        #1;
        chk("f_lat0_done", sb.mc_done, 1);
        chk("f_lat0_rd", sb.mc_rd, 13);
        chk("f_lat0_err", sb.mc_err, 1);
        tick();
        chk("f_lat0_idle", sb.mc_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mc_scoreboard.md
Name: mc_scoreboard

Overview:
- Hazard source feeding the pipeline controller. Tracks the single non-pipelined multicycle execution unit (int div/rem, FP div/sqrt) and a 64-entry destination busy map (32 int + 32 FP).
- Produces `rd_busy` (WAW) and `multicycle_hazard` (structural/RAW) for the instruction in ID.
- Produces the one-cycle completion strobe that retires the in-flight op.

Parameters:
- LAT_W, 6, width of the per-op latency field `exe_mc_lat`.
- NUM_ARCH_REGS, 32, registers per file; the busy map is 2*NUM_ARCH_REGS bits.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- id_rs1 / id_rs2 / id_rs3  in  5 each  ID source indices
- id_rs1_fp / id_rs2_fp / id_rs3_fp  in  1 each  source is FP file
- id_rs1_used / id_rs2_used / id_rs3_used  in  1 each  source actually read
- id_rd  in  5  ID destination index
- id_rd_fp  in  1  destination is FP file
- id_rd_we  in  1  ID instruction writes rd
- id_is_mc  in  1  ID instruction needs the multicycle unit
- exe_mc_start  in  1  multicycle op enters the unit this cycle
- exe_flush  in  1  EXE-stage kill; masks `exe_mc_start`
- exe_rd  in  5  destination of starting op
- exe_rd_fp  in  1  FP destination flag of starting op
- exe_rd_we  in  1  starting op writes rd
- exe_mc_lat  in  LAT_W  op latency in cycles, 1..2^LAT_W-1
- stall_pipl  in  1  global pipeline stall
- rd_busy  out  1  WAW: ID rd is busy
- multicycle_hazard  out  1  structural or RAW hazard for ID
- mc_busy  out  1  unit not IDLE
- mc_done  out  1  completion strobe (result valid to writeback)
- mc_rd  out  5  destination of completing op
- mc_rd_fp  out  1  FP flag of completing op
- mc_err  out  1  sticky: start while not IDLE, or lat=0

Behaviour:
- Reset (async, reset_n=0):
  - FSM=IDLE; counter=0; busy map=0; mc_err=0.
  - All outputs 0.
- Start condition: `start = exe_mc_start & ~exe_flush`.
- Int x0 is never marked busy. FP f0 is a normal register.
- FSM states:
  - IDLE:
    - On start, latch exe_rd/exe_rd_fp/exe_rd_we and load `cnt = exe_mc_lat-1`.
    - If exe_rd_we and not int x0, set the busy bit.
    - Go to RUN, or directly to DONE when lat=1.
    - lat=0 is treated as 1 and sets mc_err.
  - RUN:
    - cnt decrements each cycle, independent of stall_pipl.
    - At cnt==0, go to DONE on the next edge.
  - DONE:
    - mc_done=1; mc_rd/mc_rd_fp show the latched destination.
    - If stall_pipl=1, hold DONE (mc_done stays high).
    - Else clear the latched busy bit and go to IDLE. If start is high in this same cycle, go straight to RUN/DONE with the new op (back-to-back issue).
- Start in RUN, or in a stalled DONE: ignored, mc_err set, state unchanged.
- Busy bit set and clear on the same register in the same cycle: set wins.
- Latency: for lat=L, mc_done first rises L cycles after the start edge.
- mc_busy = (state != IDLE).
- rd_busy = id_rd_we & busy[id_rd_fp][id_rd] & ~(int & id_rd==0).
- multicycle_hazard = `(id_is_mc & mc_busy & ~(state==DONE & ~stall_pipl)) | raw`.
  - raw = OR over k of `(id_rsk_used & busy[id_rsk_fp][id_rsk] & ~(int & id_rsk==0))`.
- All hazard outputs are purely combinational from registered state and ID inputs. There is no registered hazard latency.
- exe_flush / branch flush never cancels an op already in the unit: that op is older than the branch and retires normally.
- Reset asserted mid-operation: FSM and busy map clear immediately; no mc_done is produced for the lost op.

Optional Feature:
- MC_EARLY_RELEASE_EN
- Defined:
  - In a DONE cycle with stall_pipl=0, the RAW term ignores a source that matches the retiring mc_rd/mc_rd_fp. The writeback forward covers it.
  - The structural term likewise releases that cycle (already in base behaviour).
- Undefined:
  - RAW stays asserted through the DONE cycle.
  - The dependent instruction leaves ID one cycle after retirement.

Test Plan:
- reset_n low mid-RUN (lat=20, cycle 5) -> mc_busy, busy map, mc_done all 0 immediately; no later mc_done.
- start div x5 lat=4; ID `add x6,x5,x1` -> multicycle_hazard=1 for 4 cycles; mc_done=1 at cycle 4 with mc_rd=5, mc_rd_fp=0; hazard 0 next cycle (0 in the DONE cycle with MC_EARLY_RELEASE_EN).
- start fdiv f3 lat=3; ID writes f3 (id_rd_fp=1) -> rd_busy=1 until retire; ID writes x3 -> rd_busy=0.
- DONE with stall_pipl=1 for 2 cycles -> mc_done held 3 cycles, f3 busy until the stall drops; then a new start of lat=2 in the release cycle -> mc_done 2 cycles later, mc_err=0.
- start with exe_rd=0 int, lat=2 -> no busy bit set; rd_busy=0 for ID rd=x0; mc_done at cycle 2.
- second exe_mc_start during RUN -> ignored, mc_err=1 sticky, first op completes at its original cycle; start with exe_flush=1 in IDLE -> no state change.
